macc_result_drain: RTL and testbench

MACC_RESULT_DRAIN -- requirements
Module: macc_result_drain

---
 rtl/macc_result_drain_pkg.sv | 23 ++
 rtl/macc_result_drain_requant_relu_sat.sv | 35 +++
 rtl/macc_result_drain.sv | 198 +++++++++++++++++++
 tb/tb_macc_result_drain.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macc_result_drain_pkg.sv
// Shared constants and helpers for the MACC result drain.
// Defaults match the MACC array that feeds this block.
package macc_result_drain_pkg;

    localparam int DEF_NUM_MACC   = 5;
    localparam int DEF_IN_WIDTH   = 20;
    localparam int DEF_NUM_PASSES = 3;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_SHIFT      = 4;

    localparam int RQ_MIN = 0;
    localparam int RQ_MAX = 127;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/macc_result_drain_requant_relu_sat.sv
// One lane of requantization: round, arithmetic shift,
// ReLU and clamp to the positive int8 range.
module requant_relu_sat
    import macc_result_drain_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int SHIFT     = DEF_SHIFT
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    output logic        [7:0]           o_byte
);

    localparam int AW1 = ACC_WIDTH + 1;
    localparam int RND = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;

    localparam logic signed [ACC_WIDTH:0] LO = AW1'(RQ_MIN);
    localparam logic signed [ACC_WIDTH:0] HI = AW1'(RQ_MAX);

    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] r;

    // Widen by one bit so the rounding add cannot wrap.
    always_comb begin
        sum = AW1'(i_acc) + AW1'(RND);
        r   = sum >>> SHIFT;
        if (r < LO) begin
            o_byte = 8'(RQ_MIN);
        end else if (r > HI) begin
            o_byte = 8'(RQ_MAX);
        end else begin
            o_byte = r[7:0];
        end
    end

endmodule

// File: rtl/macc_result_drain.sv
// Accumulates NUM_PASSES beats of MACC lane results,
// requantizes a finished group and serializes it bytewise.
module macc_result_drain
    import macc_result_drain_pkg::*;
#(
    parameter int NUM_MACC   = DEF_NUM_MACC,
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int NUM_PASSES = DEF_NUM_PASSES,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SHIFT      = DEF_SHIFT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IN_WIDTH*NUM_MACC-1:0] i_data,
    input  logic                         i_valid,
    input  logic [16*NUM_MACC-1:0]       i_bias,
    output logic [7:0]                   o_data,
    output logic [idx_w(NUM_MACC)-1:0]   o_lane,
    output logic                         o_last,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_stall,
    output logic                         o_overflow
);

    localparam int LW = idx_w(NUM_MACC);
    localparam int PW = idx_w(NUM_PASSES);

    localparam logic [LW-1:0] LANE_LAST = LW'(NUM_MACC - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);

    logic signed [ACC_WIDTH-1:0] acc_q [NUM_MACC];
    logic signed [ACC_WIDTH-1:0] acc_d [NUM_MACC];
    logic signed [ACC_WIDTH-1:0] d_ext [NUM_MACC];
    logic signed [ACC_WIDTH-1:0] b_ext [NUM_MACC];

    logic [7:0] buf_q [NUM_MACC];
    logic [7:0] buf_d [NUM_MACC];
    logic [7:0] rq    [NUM_MACC];

    logic [PW-1:0] pass_q, pass_d;
    logic          full_q, full_d;
    logic          ovf_q,  ovf_d;

    ser_state_e    state_q;
    logic [LW-1:0] lane_q;
    logic [LW-1:0] lane_nx;
    logic [7:0]    data_q;
    logic [7:0]    nxt_byte;
    logic          valid_q;
    logic          last_q;

    logic hs;
    logic last_hs;
    logic buf_free;
    logic xfer;
    logic stall;
    logic accept;

    // The output buffer frees up when idle or on its
    // final handshake, letting a FULL group move in.
    assign hs       = valid_q & i_ready;
    assign last_hs  = hs & (lane_q == LANE_LAST);
    assign buf_free = (state_q == SER_IDLE) | last_hs;
    assign xfer     = full_q & buf_free;
    assign stall    = full_q & ~xfer;
    assign accept   = i_valid & ~stall;
    assign lane_nx  = lane_q + 1'b1;

    for (genvar k = 0; k < NUM_MACC; k++) begin : g_lane
        assign d_ext[k] = ACC_WIDTH'($signed(
            i_data[k*IN_WIDTH +: IN_WIDTH]));
        assign b_ext[k] = ACC_WIDTH'($signed(
            i_bias[k*16 +: 16]));

        requant_relu_sat #(
            .ACC_WIDTH (ACC_WIDTH),
            .SHIFT     (SHIFT)
        ) u_rq (
            .i_acc  (acc_q[k]),
            .o_byte (rq[k])
        );
    end

    // Accumulate accepted beats; snapshot requantized
    // bytes into the buffer when a group transfers.
    always_comb begin
        pass_d = pass_q;
        full_d = full_q;
        ovf_d  = ovf_q | (i_valid & stall);
        for (int k = 0; k < NUM_MACC; k++) begin
            acc_d[k] = acc_q[k];
            buf_d[k] = xfer ? rq[k] : buf_q[k];
            if (accept) begin
                if (pass_q == '0) begin
                    acc_d[k] = b_ext[k] + d_ext[k];
                end else begin
                    acc_d[k] = acc_q[k] + d_ext[k];
                end
            end
        end
        if (xfer) begin
            full_d = 1'b0;
        end
        if (accept) begin
            if (pass_q == PASS_LAST) begin
                pass_d = '0;
                full_d = 1'b1;
            end else begin
                pass_d = pass_q + 1'b1;
            end
        end
    end

    // Select the buffered byte for the following lane.
    always_comb begin
        nxt_byte = '0;
        for (int k = 0; k < NUM_MACC; k++) begin
            if (LW'(k) == lane_nx) begin
                nxt_byte = buf_q[k];
            end
        end
    end

    // Datapath and control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < NUM_MACC; k++) begin
                acc_q[k] <= '0;
                buf_q[k] <= '0;
            end
        end else begin
            pass_q <= pass_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
            for (int k = 0; k < NUM_MACC; k++) begin
                acc_q[k] <= acc_d[k];
                buf_q[k] <= buf_d[k];
            end
        end
    end

    // Serializer: lane 0 comes straight from the
    // requantizers so a reload has no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            lane_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                SER_IDLE: begin
                    if (xfer) begin
                        state_q <= SER_SEND;
                        lane_q  <= '0;
                        data_q  <= rq[0];
                        valid_q <= 1'b1;
                        last_q  <= (NUM_MACC == 1);
                    end
                end
                SER_SEND: begin
                    if (xfer) begin
                        lane_q  <= '0;
                        data_q  <= rq[0];
                        valid_q <= 1'b1;
                        last_q  <= (NUM_MACC == 1);
                    end else if (last_hs) begin
                        state_q <= SER_IDLE;
                        lane_q  <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (hs) begin
                        lane_q  <= lane_nx;
                        data_q  <= nxt_byte;
                        last_q  <= (lane_nx == LANE_LAST);
                    end
                end
                default: begin
                    state_q <= SER_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_data     = data_q;
    assign o_lane     = lane_q;
    assign o_last     = last_q;
    assign o_valid    = valid_q;
    assign o_stall    = stall;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_macc_result_drain.sv
// Bench for macc_result_drain: directed scenarios plus
// randomized traffic against a group-level byte model.
module tb_macc_result_drain;

    localparam int NM = 5;
    localparam int IW = 20;
    localparam int NP = 3;
    localparam int SH = 4;

    logic           clk;
    logic           rst_n;
    logic [IW*NM-1:0] i_data;
    logic           i_valid;
    logic [16*NM-1:0] i_bias;
    logic [7:0]     o_data;
    logic [2:0]     o_lane;
    logic           o_last;
    logic           o_valid;
    logic           i_ready;
    logic           o_stall;
    logic           o_overflow;

    macc_result_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_bias     (i_bias),
        .o_data     (o_data),
        .o_lane     (o_lane),
        .o_last     (o_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_stall    (o_stall),
        .o_overflow (o_overflow)
    );

    typedef struct {
        logic [2:0] lane;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } obs_t;

    obs_t       got [$];
    logic [7:0] exp_q [$];
    obs_t       mon_o;

    int grp_d [NP][NM];
    int grp_b [NM];

    int checks;
    int passed;
    int cyc;

    logic       prev_hold;
    logic [2:0] prev_lane;
    logic [7:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record handshakes and check output stability under backpressure.
    always @(negedge clk) begin
        if (rst_n && prev_hold) begin
            checks++;
            if ({o_valid, o_lane, o_data} !==
                {1'b1, prev_lane, prev_data}) begin
                $display("FAIL hold: got v=%0b l=%0d d=%0d want v=1 l=%0d d=%0d",
                         o_valid, o_lane, o_data, prev_lane, prev_data);
            end else begin
                passed++;
            end
        end
        prev_hold = rst_n && o_valid && !i_ready;
        prev_lane = o_lane;
        prev_data = o_data;
        if (rst_n && o_valid && i_ready) begin
            mon_o.lane = o_lane;
            mon_o.data = o_data;
            mon_o.last = o_last;
            mon_o.cyc  = cyc;
            got.push_back(mon_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_byte(input longint s);
        longint t;
        t = s + (1 << (SH - 1));
        if (t < 0) return 8'd0;
        t = t / (1 << SH);
        if (t > 127) return 8'd127;
        return 8'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input int v, input int bstep);
        for (int k = 0; k < NM; k++) begin
            grp_b[k] = bstep * k;
            for (int p = 0; p < NP; p++) grp_d[p][k] = v;
        end
    endtask

    task automatic push_expected();
        longint s;
        for (int k = 0; k < NM; k++) begin
            s = grp_b[k];
            for (int p = 0; p < NP; p++) s += grp_d[p][k];
            exp_q.push_back(ref_byte(s));
        end
    endtask

    task automatic drive_beat(input int p);
        int b;
        for (int k = 0; k < NM; k++) begin
            b = (p == 0) ? grp_b[k] : int'($urandom);
            i_data[k*IW +: IW] = grp_d[p][k][IW-1:0];
            i_bias[k*16 +: 16] = b[15:0];
        end
        i_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0;
        i_data  = {IW*NM{1'b0}} | {3{$urandom}};
        i_bias  = {16*NM{1'b0}} | {3{$urandom}};
    endtask

    task automatic send_group();
        push_expected();
        for (int p = 0; p < NP; p++) begin
            drive_beat(p);
            tick();
        end
        idle_inputs();
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        for (int i = 0; i < 400 && got.size() < n; i++) tick();
        repeat (3) tick();
        ok = (got.size() >= n);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_lane, o_last, o_data, o_stall, o_overflow} !== 15'd0) begin
            $display("FAIL reset_assert: got %b want 0",
                     {o_valid, o_lane, o_last, o_data, o_stall, o_overflow});
        end else passed++;
        do_reset();
        checks++;
        if ({o_valid, o_lane, o_last, o_data, o_stall, o_overflow} !== 15'd0) begin
            $display("FAIL reset_release: got %b want 0",
                     {o_valid, o_lane, o_last, o_data, o_stall, o_overflow});
        end else passed++;
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        i_ready = 1'b1;
        fill_const(16, 0);
        send_group();
        checks++;
        if (o_valid !== 1'b0) begin
            $display("FAIL basic_early: o_valid=%b want 0", o_valid);
        end else passed++;
        tick();
        checks++;
        if ({o_valid, o_lane, o_data} !== {1'b1, 3'd0, 8'd3}) begin
            $display("FAIL basic_latency: v=%b l=%0d d=%0d want v=1 l=0 d=3",
                     o_valid, o_lane, o_data);
        end else passed++;
        wait_bytes(NM, ok);
        checks++;
        if (got.size() != NM) begin
            $display("FAIL basic_count: got %0d want %0d", got.size(), NM);
        end else passed++;
        for (int i = 0; i < NM && i < got.size(); i++) begin
            checks++;
            if ({got[i].lane, got[i].data, got[i].last} !==
                {3'(i), 8'd3, 1'(i == NM - 1)}) begin
                $display("FAIL basic_byte%0d: l=%0d d=%0d last=%b want l=%0d d=3",
                         i, got[i].lane, got[i].data, got[i].last, i);
            end else passed++;
        end
    endtask

    task automatic test_bias();
        bit ok;
        do_reset();
        i_ready = 1'b1;
        fill_const(0, 100);
        send_group();
        wait_bytes(NM, ok);
        checks++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL bias_count: got %0d want %0d", got.size(), exp_q.size());
        end else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if ({got[i].lane, got[i].data, got[i].last} !==
                {3'(i % NM), exp_q[i], 1'(i % NM == NM - 1)}) begin
                $display("FAIL bias_byte%0d: l=%0d d=%0d want d=%0d",
                         i, got[i].lane, got[i].data, exp_q[i]);
            end else passed++;
        end
    endtask

    task automatic test_relu_sat();
        bit ok;
        int lane0 [NP] = '{-100, -100, -100};
        int lane1 [NP] = '{1000, 1000, 1000};
        int lane2 [NP] = '{2024, 0, 0};
        int lane3 [NP] = '{2040, 0, 0};
        int lane4 [NP] = '{8, -3, 3};
        do_reset();
        i_ready = 1'b1;
        fill_const(0, 0);
        for (int p = 0; p < NP; p++) begin
            grp_d[p][0] = lane0[p];
            grp_d[p][1] = lane1[p];
            grp_d[p][2] = lane2[p];
            grp_d[p][3] = lane3[p];
            grp_d[p][4] = lane4[p];
        end
        send_group();
        wait_bytes(NM, ok);
        checks++;
        if (got.size() != NM) begin
            $display("FAIL relu_count: got %0d want %0d", got.size(), NM);
        end else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if ({got[i].lane, got[i].data, got[i].last} !==
                {3'(i % NM), exp_q[i], 1'(i % NM == NM - 1)}) begin
                $display("FAIL relu_byte%0d: l=%0d d=%0d want d=%0d",
                         i, got[i].lane, got[i].data, exp_q[i]);
            end else passed++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        i_ready = 1'b0;
        for (int k = 0; k < NM; k++) begin
            grp_b[k] = 0;
            for (int p = 0; p < NP; p++) grp_d[p][k] = 16 * (k + 1);
        end
        send_group();
        for (int k = 0; k < NM; k++) begin
            grp_b[k] = 7 * k;
            for (int p = 0; p < NP; p++) grp_d[p][k] = 40 * (k + 1) + p;
        end
        send_group();
        checks++;
        if ({o_stall, o_valid, o_lane} !== {1'b1, 1'b1, 3'd0}) begin
            $display("FAIL bp_stall: stall=%b v=%b l=%0d want 1 1 0",
                     o_stall, o_valid, o_lane);
        end else passed++;
        for (int k = 0; k < NM; k++) grp_d[0][k] = 90000;
        drive_beat(0);
        tick();
        idle_inputs();
        checks++;
        if ({o_overflow, o_stall} !== 2'b11) begin
            $display("FAIL bp_overflow: ovf=%b stall=%b want 1 1",
                     o_overflow, o_stall);
        end else passed++;
        repeat (4) tick();
        i_ready = 1'b1;
        wait_bytes(2 * NM, ok);
        checks++;
        if (got.size() != 2 * NM) begin
            $display("FAIL bp_count: got %0d want %0d", got.size(), 2 * NM);
        end else passed++;
        fill_const(32, 3);
        send_group();
        wait_bytes(3 * NM, ok);
        checks++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL bp_total: got %0d want %0d", got.size(), exp_q.size());
        end else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if ({got[i].lane, got[i].data, got[i].last} !==
                {3'(i % NM), exp_q[i], 1'(i % NM == NM - 1)}) begin
                $display("FAIL bp_byte%0d: l=%0d d=%0d want l=%0d d=%0d",
                         i, got[i].lane, got[i].data, i % NM, exp_q[i]);
            end else passed++;
        end
        checks++;
        if (o_overflow !== 1'b1) begin
            $display("FAIL bp_sticky: ovf=%b want 1", o_overflow);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        i_ready = 1'b1;
        fill_const(48, 1);
        send_group();
        tick();
        tick();
        fill_const(-20, 50);
        send_group();
        checks++;
        if ({o_stall, o_lane} !== {1'b0, 3'd4}) begin
            $display("FAIL b2b_align: stall=%b l=%0d want 0 4", o_stall, o_lane);
        end else passed++;
        wait_bytes(2 * NM, ok);
        checks++;
        if (got.size() != 2 * NM) begin
            $display("FAIL b2b_count: got %0d want %0d", got.size(), 2 * NM);
        end else passed++;
        if (got.size() >= 2 * NM) begin
            checks++;
            if (got[NM].cyc !== got[NM-1].cyc + 1) begin
                $display("FAIL b2b_bubble: gap %0d cycles want 1",
                         got[NM].cyc - got[NM-1].cyc);
            end else passed++;
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if ({got[i].lane, got[i].data, got[i].last} !==
                {3'(i % NM), exp_q[i], 1'(i % NM == NM - 1)}) begin
                $display("FAIL b2b_byte%0d: l=%0d d=%0d want d=%0d",
                         i, got[i].lane, got[i].data, exp_q[i]);
            end else passed++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        i_ready = 1'b1;
        fill_const(16, 2);
        send_group();
        tick();
        fill_const(500, 900);
        drive_beat(0);
        tick();
        drive_beat(1);
        tick();
        idle_inputs();
        checks++;
        if ({o_valid, o_lane} !== {1'b1, 3'd2}) begin
            $display("FAIL rmid_lane: v=%b l=%0d want 1 2", o_valid, o_lane);
        end else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_lane, o_last, o_data, o_stall, o_overflow} !== 15'd0) begin
            $display("FAIL rmid_reset: got %b want 0",
                     {o_valid, o_lane, o_last, o_data, o_stall, o_overflow});
        end else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        got.delete();
        exp_q.delete();
        fill_const(64, 10);
        send_group();
        wait_bytes(NM, ok);
        checks++;
        if (got.size() != NM) begin
            $display("FAIL rmid_count: got %0d want %0d", got.size(), NM);
        end else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if ({got[i].lane, got[i].data, got[i].last} !==
                {3'(i % NM), exp_q[i], 1'(i % NM == NM - 1)}) begin
                $display("FAIL rmid_byte%0d: l=%0d d=%0d want d=%0d",
                         i, got[i].lane, got[i].data, exp_q[i]);
            end else passed++;
        end
    endtask

    task automatic test_random();
        bit ok;
        int groups;
        int beat;
        do_reset();
        groups = 0;
        beat   = 0;
        while (groups < 25) begin
            i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (!o_stall && $urandom_range(0, 2) != 0) begin
                if (beat == 0) begin
                    for (int k = 0; k < NM; k++) begin
                        grp_b[k] = int'($signed(16'($urandom)));
                        for (int p = 0; p < NP; p++) begin
                            if ($urandom_range(0, 1) == 0)
                                grp_d[p][k] = int'($signed(20'($urandom)));
                            else
                                grp_d[p][k] = $urandom_range(0, 1200) - 300;
                        end
                    end
                    push_expected();
                end
                drive_beat(beat);
                beat = beat + 1;
                if (beat == NP) begin
                    beat   = 0;
                    groups = groups + 1;
                end
            end else begin
                idle_inputs();
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        i_ready = 1'b1;
        wait_bytes(exp_q.size(), ok);
        checks++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size());
        end else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if ({got[i].lane, got[i].data, got[i].last} !==
                {3'(i % NM), exp_q[i], 1'(i % NM == NM - 1)}) begin
                $display("FAIL rand_byte%0d: l=%0d d=%0d want l=%0d d=%0d",
                         i, got[i].lane, got[i].data, i % NM, exp_q[i]);
            end else passed++;
        end
        checks++;
        if (o_overflow !== 1'b0) begin
            $display("FAIL rand_overflow: ovf=%b want 0", o_overflow);
        end else passed++;
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        cyc       = 0;
        prev_hold = 1'b0;
        prev_lane = '0;
        prev_data = '0;
        rst_n     = 1'b0;
        i_ready   = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_bias();
        test_relu_sat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
